uart_rx: RTL and testbench

UART receiver for the Final_System serial link; the receive-side counterpart of the system's UART transmitter, sharing its frame format. It oversamples the serial line by a runtime prescale, recovers start/data/parity/stop bits by 3-sample majority vote at each bit centre, and presents the byte on a parallel bus with a one-cycle valid pulse. Parity and stop-bit failures are reported as one-cycle error pulses, and the byte is dropped.

---
 rtl/uart_rx.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
//   Recovers start / data / optional parity / stop bits from the serial line.
//   Each bit is decided by a 3-sample majority around the bit centre.
//   Received bytes appear on P_DATA together with a one-cycle data_valid pulse.
//   Parity and stop failures give one-cycle error pulses, and the byte is dropped.
//
// Ports
//   CLK           oversampling clock, Prescale cycles per bit
//   RST           asynchronous active-low reset
//   RX_IN         serial line, idle high
//   Prescale      oversampling ratio (even, 8..32), latched per frame
//   PAR_EN        frame carries a parity bit, latched per frame
//   PAR_TYP       0 even / 1 odd parity, latched per frame
//   P_DATA        last correctly received byte
//   data_valid    one-cycle pulse, P_DATA updated
//   parity_error  one-cycle pulse on parity mismatch
//   stop_error    one-cycle pulse when the stop bit samples 0
//   busy          high while a frame is in progress
//
// state  | meaning
// -------+-----------------------------------------------------
// IDLE   | line idle, waiting for rx_s low
// START  | start bit; a majority of 1 is a glitch -> IDLE
// DATA   | Data_width data bits, LSB first, shifted in at MSB
// PARITY | parity bit, mismatch flag held until STOP
// STOP   | stop bit; frame evaluated at its last cycle

module uart_rx #(
    parameter int Data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [Data_width-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int CW = (Data_width > 1) ? $clog2(Data_width) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(Data_width - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    logic                  rx_meta;
    logic                  rx_s;
    logic [5:0]            edge_cnt;
    logic [CW-1:0]         bit_cnt;
    logic [5:0]            pre_l;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic [1:0]            samp;
    logic [Data_width-1:0] shreg;
    logic                  par_err;
    logic                  stop_ok;

    logic [5:0]            half;
    logic                  at_s0;
    logic                  at_s1;
    logic                  at_dec;
    logic                  bit_end;
    logic                  maj;
    logic                  exp_par;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    assign half    = pre_l >> 1;
    assign at_s0   = (edge_cnt == half - 6'd2);
    assign at_s1   = (edge_cnt == half - 6'd1);
    assign at_dec  = (edge_cnt == half);
    assign bit_end = (edge_cnt == pre_l - 6'd1);
    // third sample is the live rx_s at the decision cycle
    assign maj     = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);
    assign exp_par = par_typ_l ? ~^shreg : ^shreg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            pre_l        <= 6'd8;
            par_en_l     <= 1'b0;
            par_typ_l    <= 1'b0;
            samp         <= 2'b11;
            shreg        <= '0;
            par_err      <= 1'b0;
            stop_ok      <= 1'b1;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;

            if (state != IDLE) begin
                edge_cnt <= bit_end ? 6'd0 : edge_cnt + 6'd1;
                if (at_s0) samp[0] <= rx_s;
                if (at_s1) samp[1] <= rx_s;
            end

            case (state)
                IDLE: begin
                    edge_cnt <= '0;
                    if (!rx_s) begin
                        state     <= START;
                        busy      <= 1'b1;
                        bit_cnt   <= '0;
                        par_err   <= 1'b0;
                        pre_l     <= Prescale;
                        par_en_l  <= PAR_EN;
                        par_typ_l <= PAR_TYP;
                    end
                end
                START: begin
                    if (at_dec && maj) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        edge_cnt <= '0;
                    end else if (bit_end) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (at_dec) shreg <= {maj, shreg[Data_width-1:1]};
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_l ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (at_dec) par_err <= (maj != exp_par);
                    if (bit_end) state <= STOP;
                end
                STOP: begin
                    if (at_dec) stop_ok <= maj;
                    if (bit_end) begin
                        if (!stop_ok) begin
                            stop_error <= 1'b1;
                        end else if (par_en_l && par_err) begin
                            parity_error <= 1'b1;
                        end else begin
                            P_DATA     <= shreg;
                            data_valid <= 1'b1;
                        end
                        // rx_s in this last cycle is already the next frame's
                        // first start sample, so chain straight into START to
                        // keep back-to-back frames on the same latency.
                        if (!rx_s) begin
                            state     <= START;
                            par_err   <= 1'b0;
                            pre_l     <= Prescale;
                            par_en_l  <= PAR_EN;
                            par_typ_l <= PAR_TYP;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

    logic       CLK_tb;
    logic       rst_n_tb;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         dv_n = 0;
    int         dv_cyc [0:63];
    logic [7:0] dv_dat [0:63];
    int         pe_n = 0;
    int         pe_cyc = 0;
    int         se_n = 0;
    int         se_cyc = 0;
    int         excl_n = 0;
    int         long_n = 0;
    int         busy_rise = 0;
    int         busy_fall = 0;
    logic       prev_busy = 1'b0;
    logic       prev_any = 1'b0;

    uart_rx #(.Data_width(8)) dut (
        .CLK          (CLK_tb),
        .RST          (rst_n_tb),
        .RX_IN        (rx_in),
        .Prescale     (prescale),
        .PAR_EN       (par_en),
        .PAR_TYP      (par_typ),
        .P_DATA       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    initial CLK_tb = 1'b0;
    always #5 CLK_tb = ~CLK_tb;

    always @(posedge CLK_tb) cyc <= cyc + 1;

    always @(negedge CLK_tb) begin
        if (data_valid && dv_n < 64) begin
            dv_cyc[dv_n] <= cyc;
            dv_dat[dv_n] <= p_data;
        end
        if (data_valid) dv_n <= dv_n + 1;
        if (parity_error) begin
            pe_n   <= pe_n + 1;
            pe_cyc <= cyc;
        end
        if (stop_error) begin
            se_n   <= se_n + 1;
            se_cyc <= cyc;
        end
        if ((32'(data_valid) + 32'(parity_error) + 32'(stop_error)) > 1) excl_n <= excl_n + 1;
        if (prev_any && (data_valid || parity_error || stop_error)) long_n <= long_n + 1;
        prev_any <= data_valid || parity_error || stop_error;
        if (busy && !prev_busy) busy_rise <= cyc;
        if (!busy && prev_busy) busy_fall <= cyc;
        prev_busy <= busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge CLK_tb);
        #1;
    endtask

    // Called #1 after a rising edge; returns the cycle index of the falling edge.
    task automatic send_frame(input logic [7:0] data, input int pre, input logic with_par,
                              input logic par_bit, input logic stop_bit, output int f);
        f = cyc;
        rx_in = 1'b0;
        repeat (pre) @(posedge CLK_tb);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx_in = data[i];
            repeat (pre) @(posedge CLK_tb);
            #1;
        end
        if (with_par) begin
            rx_in = par_bit;
            repeat (pre) @(posedge CLK_tb);
            #1;
        end
        rx_in = stop_bit;
        repeat (pre) @(posedge CLK_tb);
        #1;
        rx_in = 1'b1;
    endtask

    int f, f2, d0, p0, s0;

    initial begin
        rst_n_tb = 1'b0;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) @(posedge CLK_tb);
        #1;
        check("rst_p_data", 32'(p_data), 32'h00);
        check("rst_dv", 32'(data_valid), 0);
        check("rst_pe", 32'(parity_error), 0);
        check("rst_se", 32'(stop_error), 0);
        check("rst_busy", 32'(busy), 0);
        rst_n_tb = 1'b1;
        idle(4);

        // 0xA5, no parity, Prescale 8
        d0 = dv_n; p0 = pe_n; s0 = se_n;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, f);
        idle(8);
        check("a5_dv_count", dv_n, d0 + 1);
        check("a5_latency", dv_cyc[d0] - f, 83);
        check("a5_data", 32'(dv_dat[d0]), 32'hA5);
        check("a5_no_pe", pe_n, p0);
        check("a5_no_se", se_n, s0);
        check("a5_busy_rise", busy_rise - f, 3);
        check("a5_busy_fall", busy_fall - f, 83);

        // Prescale 16, even parity, correct parity bit 0
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        d0 = dv_n;
        send_frame(8'h48, 16, 1'b1, 1'b0, 1'b1, f);
        idle(16);
        check("even_dv_count", dv_n, d0 + 1);
        check("even_latency", dv_cyc[d0] - f, 179);
        check("even_data", 32'(p_data), 32'h48);

        // odd parity, parity bit 1
        par_typ = 1'b1;
        d0 = dv_n;
        send_frame(8'h48, 16, 1'b1, 1'b1, 1'b1, f);
        idle(16);
        check("odd_dv_count", dv_n, d0 + 1);
        check("odd_data", 32'(dv_dat[d0]), 32'h48);

        // even parity, wrong parity bit
        par_typ = 1'b0;
        d0 = dv_n; p0 = pe_n; s0 = se_n;
        send_frame(8'h48, 16, 1'b1, 1'b1, 1'b1, f);
        idle(16);
        check("perr_count", pe_n, p0 + 1);
        check("perr_latency", pe_cyc - f, 179);
        check("perr_no_dv", dv_n, d0);
        check("perr_no_se", se_n, s0);
        check("perr_p_data", 32'(p_data), 32'h48);

        // stop bit 0, no parity
        prescale = 6'd8; par_en = 1'b0;
        d0 = dv_n; p0 = pe_n; s0 = se_n;
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, f);
        idle(16);
        check("serr_count", se_n, s0 + 1);
        check("serr_latency", se_cyc - f, 83);
        check("serr_no_dv", dv_n, d0);
        check("serr_p_data", 32'(p_data), 32'h48);

        // bad parity and bad stop: stop error wins
        par_en = 1'b1;
        d0 = dv_n; p0 = pe_n; s0 = se_n;
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b0, f);
        idle(16);
        check("both_se", se_n, s0 + 1);
        check("both_no_pe", pe_n, p0);
        check("both_no_dv", dv_n, d0);

        // recovery frame 0x11
        par_en = 1'b0;
        d0 = dv_n;
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, f);
        idle(8);
        check("rec_dv_count", dv_n, d0 + 1);
        check("rec_data", 32'(p_data), 32'h11);

        // 2-cycle glitch
        d0 = dv_n; p0 = pe_n; s0 = se_n;
        f = cyc;
        rx_in = 1'b0;
        repeat (2) @(posedge CLK_tb);
        #1;
        idle(20);
        check("glitch_busy_rise", busy_rise - f, 3);
        check("glitch_busy_fall", busy_fall - f, 8);
        check("glitch_busy_now", 32'(busy), 0);
        check("glitch_no_dv", dv_n, d0);
        check("glitch_no_pe", pe_n, p0);
        check("glitch_no_se", se_n, s0);

        // back-to-back 0x00 then 0xFF
        d0 = dv_n;
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, f);
        send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, f2);
        idle(12);
        check("b2b_dv_count", dv_n, d0 + 2);
        check("b2b_spacing", dv_cyc[d0 + 1] - dv_cyc[d0], 80);
        check("b2b_data0", 32'(dv_dat[d0]), 32'h00);
        check("b2b_data1", 32'(dv_dat[d0 + 1]), 32'hFF);
        check("b2b_busy_fall", busy_fall - f, 163);

        // reset during data bits
        d0 = dv_n; p0 = pe_n; s0 = se_n;
        rx_in = 1'b0;
        repeat (8) @(posedge CLK_tb);
        #1;
        rx_in = 1'b1;
        repeat (8) @(posedge CLK_tb);
        #1;
        rx_in = 1'b0;
        repeat (8) @(posedge CLK_tb);
        #1;
        check("abort_busy_before", 32'(busy), 1);
        rst_n_tb = 1'b0;
        #2;
        check("abort_busy", 32'(busy), 0);
        check("abort_p_data", 32'(p_data), 32'h00);
        rx_in = 1'b1;
        repeat (3) @(posedge CLK_tb);
        #1;
        rst_n_tb = 1'b1;
        idle(4);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, f);
        idle(8);
        check("post_rst_dv_count", dv_n, d0 + 1);
        check("post_rst_latency", dv_cyc[d0] - f, 83);
        check("post_rst_data", 32'(p_data), 32'h5A);
        check("post_rst_no_err", pe_n + se_n, p0 + s0);

        check("pulse_exclusive", excl_n, 0);
        check("pulse_width", long_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
